// File: rtl/lab4_clkgen_pkg.sv
// Purpose: shared types and sizing helpers for the lab4 clock-enable generator.
//   state_e       : config/settle FSM states
//   cnt_w_f       : width of a counter spanning 0..cycles-1
//   ch_w_f        : width of the config channel select
//   default_inc_f : half-rate increment (2^(acc_w-1)) for a given accumulator width
package lab4_clkgen_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_LOCKED = 2'd1,
        ST_APPLY  = 2'd2
    } state_e;

    function automatic int unsigned cnt_w_f(input int unsigned cycles);
        return (cycles > 1) ? 32'($clog2(cycles)) : 32'd1;
    endfunction

    // One spare bit so out-of-range channel numbers can be expressed and flagged.
    function automatic int unsigned ch_w_f(input int unsigned num_ch);
        return 32'($clog2(num_ch)) + 32'd1;
    endfunction

    function automatic logic [31:0] default_inc_f(input int unsigned acc_w);
        return 32'd1 << (acc_w - 32'd1);
    endfunction

endpackage

// File: rtl/lab4_clk_en_gen_if.sv
// Purpose: config request bus of the clock-enable generator.
//   cfg_valid/cfg_ready : request handshake
//   cfg_ch              : target channel (may exceed channel count -> cfg_err)
//   cfg_inc/cfg_phase   : new increment and accumulator load value
//   cfg_err             : one-cycle pulse for an accepted out-of-range request
// master = requester, slave = generator.
interface lab4_clk_en_gen_if #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned CH_W  = 3
) ();

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [ACC_W-1:0] cfg_inc;
    logic [ACC_W-1:0] cfg_phase;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_inc,
        output cfg_phase,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_inc,
        input  cfg_phase,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/lab4_nco_ch.sv
// Purpose: one phase-accumulator NCO channel.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   en_i           : run enable (acc and sq hold, tick low when 0)
//   load_i         : load inc_i/phase_i this cycle (overrides en_i, tick forced low)
//   tick_o         : registered accumulator carry
//   sq_o           : registered accumulator MSB
module lab4_nco_ch
    import lab4_clkgen_pkg::*;
#(
    parameter int unsigned      ACC_W   = 32,
    parameter logic [ACC_W-1:0] RST_INC = ACC_W'(default_inc_f(ACC_W))
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [ACC_W-1:0] inc_i,
    input  logic [ACC_W-1:0] phase_i,
    output logic             tick_o,
    output logic             sq_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic [ACC_W:0]   sum_c;

    // Extra top bit of the sum is the wrap carry.
    assign sum_c = {1'b0, acc_q} + {1'b0, inc_q};

    // Next-state: load has priority, otherwise advance when enabled.
    always_comb begin
        acc_d  = acc_q;
        inc_d  = inc_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        if (load_i) begin
            acc_d = phase_i;
            inc_d = inc_i;
            sq_d  = phase_i[ACC_W-1];
        end else if (en_i) begin
            acc_d  = sum_c[ACC_W-1:0];
            tick_d = sum_c[ACC_W];
            sq_d   = sum_c[ACC_W-1];
        end
    end

    // Channel state register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            acc_q  <= '0;
            inc_q  <= RST_INC;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            inc_q  <= inc_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;

endmodule

// File: rtl/lab4_clk_en_gen.sv
// Purpose: multi-channel fractional clock-enable generator with settle/lock tracking.
//   refclk, rst_n : clock, synchronous active-low reset
//   cfg           : config request bus (slave side)
//   ch_enable     : per-channel run enable
//   tick          : per-channel one-cycle strobe on accumulator carry
//   sq            : per-channel accumulator MSB
//   locked        : all channel configs unchanged for LOCK_CYCLES cycles
module lab4_clk_en_gen
    import lab4_clkgen_pkg::*;
#(
    parameter int unsigned      NUM_CH      = 4,
    parameter int unsigned      ACC_W       = 32,
    parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(default_inc_f(ACC_W)),
    parameter int unsigned      LOCK_CYCLES = 1024
) (
    input  logic              refclk,
    input  logic              rst_n,
    lab4_clk_en_gen_if.slave  cfg,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic              locked
);

    localparam int unsigned      CH_W     = ch_w_f(NUM_CH);
    localparam int unsigned      CNT_W    = cnt_w_f(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             locked_q, locked_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] phase_q, phase_d;

    logic             accept_c;
    logic             ch_ok_c;
    logic             apply_c;

    assign accept_c = cfg.cfg_valid && ready_q;
    assign ch_ok_c  = (32'(cfg.cfg_ch) < NUM_CH);
    assign apply_c  = (state_q == ST_APPLY);

    // FSM next-state, settle counter and request capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        ready_d  = ready_q;
        err_d    = 1'b0;
        ch_d     = ch_q;
        inc_d    = inc_q;
        phase_d  = phase_q;

        case (state_q)
            ST_SETTLE: begin
                ready_d  = 1'b1;
                locked_d = 1'b0;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_LOCKED;
                    locked_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                ready_d  = 1'b1;
                locked_d = 1'b1;
            end
            ST_APPLY: begin
                state_d  = ST_SETTLE;
                cnt_d    = '0;
                ready_d  = 1'b1;
                locked_d = 1'b0;
            end
            default: begin
                state_d  = ST_SETTLE;
                cnt_d    = '0;
                ready_d  = 1'b0;
                locked_d = 1'b0;
            end
        endcase

        // ready_q is only high in SETTLE/LOCKED, so this never fires in APPLY.
        if (accept_c) begin
            if (ch_ok_c) begin
                state_d  = ST_APPLY;
                cnt_d    = '0;
                ready_d  = 1'b0;
                locked_d = 1'b0;
                ch_d     = CH_W'(cfg.cfg_ch);
                inc_d    = ACC_W'(cfg.cfg_inc);
                phase_d  = ACC_W'(cfg.cfg_phase);
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // FSM and capture registers.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q  <= ST_SETTLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            ch_q     <= '0;
            inc_q    <= '0;
            phase_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            ch_q     <= ch_d;
            inc_q    <= inc_d;
            phase_q  <= phase_d;
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;
    assign locked        = locked_q;

    // One NCO per channel; only the captured target is loaded during APPLY.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        lab4_nco_ch #(
            .ACC_W   (ACC_W),
            .RST_INC (DEFAULT_INC)
        ) u_nco (
            .clk_i   (refclk),
            .rst_n_i (rst_n),
            .en_i    (ch_enable[i]),
            .load_i  (apply_c && (ch_q == CH_W'(i))),
            .inc_i   (inc_q),
            .phase_i (phase_q),
            .tick_o  (tick[i]),
            .sq_o    (sq[i])
        );
    end

endmodule

// File: tb/tb_lab4_clk_en_gen.sv
// Purpose: directed self-checking bench for lab4_clk_en_gen
// (NUM_CH=4, ACC_W=8, LOCK_CYCLES=16, default increment 128).
module tb_lab4_clk_en_gen;
    import lab4_clkgen_pkg::*;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned ACC_W  = 8;
    localparam int unsigned LOCK   = 16;
    localparam int unsigned CH_W   = ch_w_f(NUM_CH);

    logic              refclk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] ch_enable;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic              locked;

    int n_checks = 0;
    int n_errs   = 0;
    int edge_n   = 0;

    always #5 refclk = ~refclk;

    lab4_clk_en_gen_if #(.ACC_W(ACC_W), .CH_W(CH_W)) cfg_if ();

    lab4_clk_en_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK)
    ) u_dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .cfg       (cfg_if.slave),
        .ch_enable (ch_enable),
        .tick      (tick),
        .sq        (sq),
        .locked    (locked)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; all sampling and driving happens on the falling edge.
    task automatic step();
        @(negedge refclk);
        edge_n++;
    endtask

    // Release reset and check lock timing plus the default half-rate pattern.
    task automatic release_check(input string tag);
        rst_n  = 1'b1;
        edge_n = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("%s_lock%0d", tag, k), 32'(locked), 32'(k == 16));
            check($sformatf("%s_tick%0d", tag, k), 32'(tick), (k % 2 == 0) ? 32'hF : 32'h0);
            check($sformatf("%s_sq%0d", tag, k), 32'(sq), (k % 2 == 1) ? 32'hF : 32'h0);
            check($sformatf("%s_rdy%0d", tag, k), 32'(cfg_if.cfg_ready), 32'd1);
        end
    endtask

    // Issue one valid request; returns just after the APPLY edge.
    task automatic cfg_write(input int ch, input logic [7:0] inc, input logic [7:0] phase);
        cfg_if.cfg_ch    = CH_W'(ch);
        cfg_if.cfg_inc   = inc;
        cfg_if.cfg_phase = phase;
        cfg_if.cfg_valid = 1'b1;
        step();
        check("acc_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
        check("acc_lock_drop", 32'(locked), 32'd0);
        check("acc_no_err", 32'(cfg_if.cfg_err), 32'd0);
        cfg_if.cfg_valid = 1'b0;
        step();
        check("apply_ready", 32'(cfg_if.cfg_ready), 32'd1);
        check("apply_tick0", 32'(tick[ch]), 32'd0);
        check("apply_lock", 32'(locked), 32'd0);
    endtask

    int  a1;
    int  cnt;
    bit  h;
    bit  frozen;
    int  durs [2] = '{10, 3};

    initial begin
        rst_n            = 1'b0;
        ch_enable        = 4'hF;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_inc   = '0;
        cfg_if.cfg_phase = '0;

        // Reset state
        repeat (3) step();
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_sq", 32'(sq), 32'd0);
        check("rst_lock", 32'(locked), 32'd0);
        check("rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
        check("rst_err", 32'(cfg_if.cfg_err), 32'd0);

        release_check("rel");

        // ch1 inc=64 phase=0 while locked
        cfg_write(1, 8'd64, 8'd0);
        a1 = edge_n;
        for (int j = 1; j <= 16; j++) begin
            step();
            check($sformatf("ch1_tick%0d", j), 32'(tick[1]), 32'(j % 4 == 0));
            check($sformatf("ch1_sq%0d", j), 32'(sq[1]), 32'((j % 4) >= 2));
            check($sformatf("others_tick%0d", j), 32'(tick & 4'b1101),
                  (edge_n % 2 == 0) ? 32'hD : 32'h0);
            check($sformatf("relock%0d", j), 32'(locked), 32'(j == 16));
        end

        // ch2 inc=0: never ticks
        cfg_write(2, 8'd0, 8'd0);
        cnt = 0;
        for (int j = 0; j < 512; j++) begin
            step();
            if (tick[2]) cnt++;
        end
        check("inc0_ticks", 32'(cnt), 32'd0);

        // ch2 inc=255: 255 ticks per 256 cycles
        cfg_write(2, 8'd255, 8'd0);
        cnt = 0;
        for (int j = 0; j < 256; j++) begin
            step();
            if (tick[2]) cnt++;
        end
        check("inc255_ticks", 32'(cnt), 32'd255);

        // ch2 inc=3 phase=250: 253, then wrap to 0
        cfg_write(2, 8'd3, 8'd250);
        check("ph_sq0", 32'(sq[2]), 32'd1);
        step();
        check("ph_tick1", 32'(tick[2]), 32'd0);
        check("ph_sq1", 32'(sq[2]), 32'd1);
        step();
        check("ph_tick2", 32'(tick[2]), 32'd1);
        check("ph_sq2", 32'(sq[2]), 32'd0);
        step();
        check("ph_tick3", 32'(tick[2]), 32'd0);
        repeat (13) step();
        check("ph_relock", 32'(locked), 32'd1);

        // Out-of-range channel: error pulse only
        cfg_if.cfg_ch    = CH_W'(5);
        cfg_if.cfg_inc   = 8'd7;
        cfg_if.cfg_phase = 8'd9;
        cfg_if.cfg_valid = 1'b1;
        step();
        check("bad_err", 32'(cfg_if.cfg_err), 32'd1);
        check("bad_lock", 32'(locked), 32'd1);
        check("bad_ready", 32'(cfg_if.cfg_ready), 32'd1);
        cfg_if.cfg_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            step();
            check($sformatf("bad_err_clr%0d", j), 32'(cfg_if.cfg_err), 32'd0);
            check($sformatf("bad_lock%0d", j), 32'(locked), 32'd1);
            check($sformatf("bad_ch1_%0d", j), 32'(tick[1]), 32'((edge_n - a1) % 4 == 0));
            check($sformatf("bad_ch03_%0d", j), 32'(tick & 4'b1001),
                  (edge_n % 2 == 0) ? 32'h9 : 32'h0);
        end

        // Two writes inside one settle window: the count restarts
        cfg_write(0, 8'd128, 8'd0);
        repeat (5) step();
        check("b2b_lock_mid", 32'(locked), 32'd0);
        check("b2b_ready_mid", 32'(cfg_if.cfg_ready), 32'd1);
        cfg_write(0, 8'd128, 8'd0);
        repeat (15) step();
        check("b2b_lock15", 32'(locked), 32'd0);
        step();
        check("b2b_lock16", 32'(locked), 32'd1);

        // ch3 disable: tick low, sq frozen, phase resumes
        h = (edge_n % 2 == 1);
        for (int d = 0; d < 2; d++) begin
            frozen       = h;
            ch_enable[3] = 1'b0;
            for (int j = 1; j <= durs[d]; j++) begin
                step();
                check($sformatf("dis%0d_tick%0d", d, j), 32'(tick[3]), 32'd0);
                check($sformatf("dis%0d_sq%0d", d, j), 32'(sq[3]), 32'(frozen));
            end
            ch_enable[3] = 1'b1;
            for (int j = 1; j <= 2; j++) begin
                step();
                check($sformatf("en%0d_tick%0d", d, j), 32'(tick[3]), 32'(h));
                h = !h;
                check($sformatf("en%0d_sq%0d", d, j), 32'(sq[3]), 32'(h));
            end
        end

        // Reset on the APPLY cycle discards the write
        cfg_if.cfg_ch    = CH_W'(2);
        cfg_if.cfg_inc   = 8'd5;
        cfg_if.cfg_phase = 8'd77;
        cfg_if.cfg_valid = 1'b1;
        step();
        check("rst_apply_acc", 32'(cfg_if.cfg_ready), 32'd0);
        cfg_if.cfg_valid = 1'b0;
        rst_n            = 1'b0;
        step();
        check("rst2_tick", 32'(tick), 32'd0);
        check("rst2_sq", 32'(sq), 32'd0);
        check("rst2_lock", 32'(locked), 32'd0);
        check("rst2_ready", 32'(cfg_if.cfg_ready), 32'd0);
        check("rst2_err", 32'(cfg_if.cfg_err), 32'd0);
        release_check("rel2");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
